// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op encoding and the
// per-bit operation helper that callers replicate across their own width.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

    // Single-bit result; every op is bitwise, so a WIDTH-bit result is this
    // function applied independently to each bit position.
    function automatic logic apply_op(input op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_NOT_A: r = ~a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One valid+data register slice of the logic unit pipeline. Data only
// moves when a valid entry is loaded, so an empty slice keeps its old word.
module logic_unit_stage
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv) begin
            v_d = in_v;
            if (in_v) begin
                d_d = in_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/pipelined_logic_unit.sv
// Bitwise op unit followed by a STAGES-deep valid/ready pipeline whose empty
// slices always advance, so bubbles collapse while the output is stalled.
module pipelined_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0]  res;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = apply_op(op_t'(op), a[i], b[i]);
        end
    end

    // Stage i may advance if it, or any stage downstream of it, has a hole,
    // or the consumer is taking the head entry this cycle.
    always_comb begin : adv_chain
        logic room;
        adv  = '0;
        room = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            room   = room | ~v[i];
            adv[i] = room;
        end
    end

    assign in_ready = adv[0] & ~rst;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .adv  (adv[gi]),
                .in_v (in_valid),
                .in_d (res),
                .v    (v[gi]),
                .d    (d[gi])
            );
        end else begin : g_body
            logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .adv  (adv[gi]),
                .in_v (v[gi-1]),
                .in_d (d[gi-1]),
                .v    (v[gi]),
                .d    (d[gi])
            );
        end
    end

    assign out_valid = v[STAGES-1];
    assign c         = d[STAGES-1];

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed vectors on the default 8-bit/2-stage unit plus a random
// scoreboard sweep over 1-bit/1-stage and 32-bit/4-stage instances.
module tb_pipelined_logic_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, c;
    logic [2:0] op;

    pipelined_logic_unit #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    logic        sw_valid, sw_rdy1, sw_rdy4;
    logic [31:0] sw_a, sw_b;
    logic [2:0]  sw_op;
    logic        ir1, ov1, ir4, ov4;
    logic [0:0]  c1;
    logic [31:0] c4;

    pipelined_logic_unit #(.WIDTH(1), .STAGES(1)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir1),
        .a(sw_a[0:0]), .b(sw_b[0:0]), .op(sw_op), .out_valid(ov1), .out_ready(sw_rdy1), .c(c1)
    );

    pipelined_logic_unit #(.WIDTH(32), .STAGES(4)) u_sw4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir4),
        .a(sw_a), .b(sw_b), .op(sw_op), .out_valid(ov4), .out_ready(sw_rdy4), .c(c4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    logic [7:0] q8[$];

    // Evaluate handshakes for the current cycle, then move to just after the next edge.
    task automatic tick();
        logic [31:0] m;
        #1;
        if (out_valid && out_ready) begin
            if (q8.size() == 0) check("dut_unexpected_output", 32'(c), 32'hDEAD);
            else check("dut_fifo_order", 32'(c), 32'(q8.pop_front()));
        end
        if (in_valid && in_ready) begin
            m = model(op, 32'(a), 32'(b));
            q8.push_back(m[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t q1[$];
    sb_t q4[$];

    task automatic sw_eval(input int cyc, input bit exact_lat);
        sb_t e;
        #1;
        if (ov1 && sw_rdy1) begin
            if (q1.size() == 0) check("sw1_unexpected_output", 32'(c1), 32'hDEAD);
            else begin
                e = q1.pop_front();
                check("sw1_data", 32'(c1), e.data);
                if (exact_lat) check("sw1_latency", 32'(cyc - e.cyc), 32'd1);
                else check("sw1_latency_min", 32'(cyc - e.cyc >= 1), 32'd1);
            end
        end
        if (ov4 && sw_rdy4) begin
            if (q4.size() == 0) check("sw4_unexpected_output", c4, 32'hDEAD);
            else begin
                e = q4.pop_front();
                check("sw4_data", c4, e.data);
                if (exact_lat) check("sw4_latency", 32'(cyc - e.cyc), 32'd4);
                else check("sw4_latency_min", 32'(cyc - e.cyc >= 4), 32'd1);
            end
        end
        if (sw_valid && ir1) q1.push_back('{data: model(sw_op, sw_a, sw_b) & 32'h1, cyc: cyc});
        if (sw_valid && ir4) q4.push_back('{data: model(sw_op, sw_a, sw_b), cyc: cyc});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         acc;
        logic [7:0] nxt;
        logic [7:0] prev_c;
        logic       prev_stall;

        tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
        tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
        tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C};
        tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F};
        tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03};
        tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3};
        tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'h0F};
        tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0};

        sw_valid = 1'b0; sw_rdy1 = 1'b1; sw_rdy4 = 1'b1;
        sw_a = '0; sw_b = '0; sw_op = '0;

        // Reset with a transaction held on the input.
        rst = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        // First accept after reset: latency measured in edges.
        in_valid = 1'b1; op = 3'd7; a = 8'h5A; b = 8'h00;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("first_latency", 32'(n), 32'd2);
        check("first_data", 32'(c), 32'h5A);
        tick();

        // Streaming, one op per cycle, no gaps.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                check("stream_out_valid", 32'(out_valid), 32'd1);
                check("stream_c", 32'(c), 32'(tbl[i-2].exp));
            end else begin
                check("stream_out_valid_idle", 32'(out_valid), 32'd0);
            end
            tick();
        end
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: five cycles of stall with input pressure.
        out_ready = 1'b0; nxt = 8'h00; acc = 0; prev_stall = 1'b0; prev_c = 8'h00;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; op = 3'd7; b = 8'h00; a = 8'h10 + nxt;
            #1;
            if (prev_stall) check("stall_c_stable", 32'(c), 32'(prev_c));
            if (in_ready) begin
                acc++;
                nxt = nxt + 8'd1;
            end
            prev_stall = out_valid;
            prev_c     = c;
            tick();
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(c), 32'h10);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = 8'h10 + nxt;
            #1;
            check("bp_pass_in_ready", 32'(in_ready), 32'd1);
            check("bp_pass_out_valid", 32'(out_valid), 32'd1);
            if (in_ready) nxt = nxt + 8'd1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("bp_queue_empty", 32'(q8.size()), 32'd0);
        check("bp_idle", 32'(out_valid), 32'd0);

        // Bubble collapse under a stalled output.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 8'h21;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; a = 8'h22;
        #1;
        check("bubble_accept2", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bubble_full_in_ready", 32'(in_ready), 32'd0);
        check("bubble_full_valid", 32'(out_valid), 32'd1);
        check("bubble_head", 32'(c), 32'h21);
        out_ready = 1'b1;
        tick();
        check("bubble_second_valid", 32'(out_valid), 32'd1);
        check("bubble_second", 32'(c), 32'h22);
        tick();
        check("bubble_done", 32'(out_valid), 32'd0);

        // Mid-flight reset discards two queued results.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 8'h31;
        tick();
        a = 8'h32;
        tick();
        rst = 1'b1; a = 8'h33;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        q8.delete();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("midrst_never_emitted", 32'(out_valid), 32'd0);
        end

        // Random sweep: unstalled phase checks exact latency, then random ready.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            sw_valid = ($urandom_range(0, 9) < 7);
            sw_a     = $urandom;
            sw_b     = $urandom;
            sw_op    = 3'($urandom_range(0, 7));
            sw_rdy1  = (cyc < 300) ? 1'b1 : 1'($urandom_range(0, 1));
            sw_rdy4  = (cyc < 300) ? 1'b1 : 1'($urandom_range(0, 1));
            sw_eval(cyc, cyc < 300);
        end
        sw_valid = 1'b0; sw_rdy1 = 1'b1; sw_rdy4 = 1'b1;
        for (int cyc = 1500; cyc < 1510; cyc++) sw_eval(cyc, 1'b0);
        check("sw1_drained", 32'(q1.size()), 32'd0);
        check("sw4_drained", 32'(q4.size()), 32'd0);
        check("sw1_idle", 32'(ov1), 32'd0);
        check("sw4_idle", 32'(ov4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
